// File: rtl/dram_cmd_scheduler.sv
// Request queue and closed-page DDR4 command sequencer driven by trace time.
// Requests are admitted once simulation time reaches their trace time, queued
// in order, and the head request is walked through ACT -> RD/WR -> PRE with
// DRAM timing counted in CPU cycles (one DRAM cycle = two CPU cycles).

package dram_cmd_scheduler_pkg;
    localparam int ADDRESS_WIDTH = 33;

    typedef struct packed {
        logic                     op_ready_s;
        logic [31:0]              CPU_clock_count;
        logic [1:0]               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
    } parser_out_struct;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_IFETCH = 2'd2;

    localparam logic [1:0] CMD_ACT = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam logic [1:0] CMD_PRE = 2'd3;
endpackage

module dram_cmd_scheduler
    import dram_cmd_scheduler_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int T_RCD   = 24,
    parameter int T_CL    = 24,
    parameter int T_CWL   = 20,
    parameter int T_BURST = 4,
    parameter int T_RP    = 24
) (
    input  logic                       CPU_clock,
    input  logic                       rst,
    input  parser_out_struct           parser_output,
    output logic                       req_accept,
    output logic                       cmd_valid,
    output logic [1:0]                 cmd,
    output logic [1:0]                 cmd_bg,
    output logic [1:0]                 cmd_bank,
    output logic [14:0]                cmd_addr,
    output logic [31:0]                sim_time,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       q_full,
    output logic                       q_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam int MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int MAX_B = ((T_CL > T_CWL) ? T_CL : T_CWL) + T_BURST;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int WAIT_W = $clog2(2*MAX_T+1);

    // Cycle counts after the issuing command at which the next step happens.
    localparam logic [WAIT_W-1:0] RCD_CYC = WAIT_W'(2*T_RCD);
    localparam logic [WAIT_W-1:0] RD_CYC  = WAIT_W'(2*(T_CL+T_BURST));
    localparam logic [WAIT_W-1:0] WR_CYC  = WAIT_W'(2*(T_CWL+T_BURST));
    localparam logic [WAIT_W-1:0] RP_LAST = WAIT_W'(2*T_RP-1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RCD  = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_WAIT_RP   = 2'd3
    } state_t;

    typedef struct packed {
        logic        is_write;
        logic [14:0] row;
        logic [7:0]  col;
        logic [1:0]  bank;
        logic [1:0]  bg;
    } entry_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [31:0]        sim_time_q, sim_time_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [DEPTH];

    entry_t             new_entry;
    entry_t             head;
    logic               head_valid;
    logic               is_mem_op;
    logic               push;
    logic               pop;
    logic               skip;

    // Byte-within-burst address bits carry no command information.
    logic               unused_low_addr;
    assign unused_low_addr = ^parser_output.address[5:0];

    assign q_count = count_q;
    assign q_full  = (count_q == CNT_W'(DEPTH));
    assign q_empty = (count_q == '0);
    assign sim_time = sim_time_q;

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = !q_empty;

    assign is_mem_op = (parser_output.opcode == OP_READ)  ||
                       (parser_output.opcode == OP_WRITE) ||
                       (parser_output.opcode == OP_IFETCH);

    // Admission: request time reached and room in the queue; a pop in the
    // same cycle does not free a slot for this request.
    assign req_accept = parser_output.op_ready_s &&
                        (parser_output.CPU_clock_count <= sim_time_q) &&
                        !q_full;
    assign push = req_accept && is_mem_op;

    assign new_entry.is_write = (parser_output.opcode == OP_WRITE);
    assign new_entry.row      = parser_output.address[32:18];
    assign new_entry.col      = parser_output.address[17:10];
    assign new_entry.bank     = parser_output.address[9:8];
    assign new_entry.bg       = parser_output.address[7:6];

    // Jump straight to the next request's trace time when nothing is pending.
    assign skip = q_empty && (state_q == S_IDLE) && parser_output.op_ready_s &&
                  ({1'b0, parser_output.CPU_clock_count} > ({1'b0, sim_time_q} + 33'd1));
    assign sim_time_d = skip ? parser_output.CPU_clock_count : sim_time_q + 32'd1;

    // Simulation time register.
    always_ff @(posedge CPU_clock) begin
        if (rst) begin
            sim_time_q <= '0;
        end else begin
            sim_time_q <= sim_time_d;
        end
    end

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue pointers and occupancy.
    always_ff @(posedge CPU_clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Queue storage; contents are qualified by the occupancy count.
    always_ff @(posedge CPU_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge CPU_clock) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Command sequencing: next state, wait counter, command strobe and fields.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        pop       = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        cmd_bg    = 2'd0;
        cmd_bank  = 2'd0;
        cmd_addr  = 15'd0;
        case (state_q)
            S_IDLE: begin
                if (head_valid && !sim_time_q[0]) begin
                    cmd_valid = 1'b1;
                    cmd       = CMD_ACT;
                    cmd_bg    = head.bg;
                    cmd_bank  = head.bank;
                    cmd_addr  = head.row;
                    wait_d    = WAIT_W'(1);
                    state_d   = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (wait_q == RCD_CYC) begin
                    cmd_valid = 1'b1;
                    cmd       = head.is_write ? CMD_WR : CMD_RD;
                    cmd_bg    = head.bg;
                    cmd_bank  = head.bank;
                    cmd_addr  = {7'b0, head.col};
                    wait_d    = WAIT_W'(1);
                    state_d   = S_WAIT_DATA;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WAIT_DATA: begin
                if (wait_q == (head.is_write ? WR_CYC : RD_CYC)) begin
                    cmd_valid = 1'b1;
                    cmd       = CMD_PRE;
                    cmd_bg    = head.bg;
                    cmd_bank  = head.bank;
                    wait_d    = WAIT_W'(1);
                    state_d   = S_WAIT_RP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WAIT_RP: begin
                // Pop one cycle early so the next ACT can go out exactly tRP after PRE.
                if (wait_q == RP_LAST) begin
                    pop     = 1'b1;
                    wait_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = '0;
            end
        endcase
    end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Sits between the trace parser and the DRAM command output.
- Admits parsed requests at their trace time into an in-order request queue. Maintains simulation time (CPU clock count).
- Sequences the head request through a closed-page DDR4 command FSM (ACT, RD/WR, PRE) with timing enforced in DRAM cycles, where one DRAM cycle is two CPU cycles.
- Skips simulation time forward when the queue is idle.

Parameters:
- DEPTH, 16, request queue entries (power of 2, ≥2).
- T_RCD, 24, ACT-to-RD/WR delay in DRAM cycles.
- T_CL, 24, read CAS latency in DRAM cycles.
- T_CWL, 20, write CAS latency in DRAM cycles.
- T_BURST, 4, burst duration in DRAM cycles.
- T_RP, 24, PRE-to-next-ACT delay in DRAM cycles.

Ports:
- CPU_clock  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- parser_output  in  parser_out_struct  request from the parser: op_ready_s, CPU_clock_count (32), opcode, address (ADDRESS_WIDTH=33). The parser holds these fields stable until req_accept.
- req_accept  out  1  the current parser request is consumed at this edge.
- cmd_valid  out  1  one-cycle DRAM command strobe.
- cmd  out  2  command code: ACT=0, RD=1, WR=2, PRE=3.
- cmd_bg  out  2  bank group.
- cmd_bank  out  2  bank.
- cmd_addr  out  15  row for ACT; {7'b0, column} for RD/WR; 0 for PRE.
- sim_time  out  32  current CPU clock count.
- q_count  out  $clog2(DEPTH+1)  number of occupied queue entries.
- q_full  out  1  q_count == DEPTH.
- q_empty  out  1  q_count == 0.

Behaviour:
- Reset:
  - On the first active edge of rst: sim_time=0, queue emptied, FSM=IDLE.
  - All outputs are 0, except q_empty=1.
  - A reset mid-operation abandons the in-flight request; no PRE is issued.
- sim_time:
  - Normally increments by 1 every cycle.
  - Skip rule: if q_empty, FSM=IDLE, op_ready_s=1 and CPU_clock_count > sim_time+1, then sim_time loads CPU_clock_count instead.
- Admission:
  - req_accept=1 (combinational) iff op_ready_s && CPU_clock_count <= sim_time && !q_full.
  - q_full blocks admission even if a pop occurs in the same cycle (no bypass).
  - Opcode 0 (read) and 2 (ifetch) enqueue as READ; opcode 1 enqueues as WRITE.
  - Any other opcode (incl. NOP) is accepted and discarded; the queue is unchanged.
- Address split:
  - row = addr[32:18], column = addr[17:10], bank = addr[9:8], bg = addr[7:6]. Bits [5:0] are ignored.
- Queue:
  - Circular FIFO with wrapping rd/wr pointers.
  - An entry written at edge E is visible to the FSM in the cycle after E.
  - Simultaneous enqueue and pop leaves q_count unchanged.
- DRAM cycle alignment: commands issue only in cycles where sim_time[0]==0.
- FSM states and transitions:
  - IDLE: when the head is valid and sim_time even, issue ACT (row), then go to WAIT_RCD.
  - WAIT_RCD: when sim_time == ACT time + 2*T_RCD, issue RD or WR (column), then go to WAIT_DATA.
  - WAIT_DATA: when sim_time == RD/WR time + 2*(T_CL+T_BURST) for reads, or + 2*(T_CWL+T_BURST) for writes, issue PRE, then go to WAIT_RP.
  - WAIT_RP: the head is popped at the edge ending cycle PRE time + 2*T_RP − 1, then go to IDLE. The next ACT can therefore issue at PRE time + 2*T_RP.
- Wait counters: count CPU cycles, width ≥ $clog2(2*max timing+1). They are unaffected by the sim_time skip, because a skip only occurs in IDLE.
- Command fields: cmd_valid is high for exactly one cycle per command. cmd/bg/bank/addr are valid only while cmd_valid=1 and are 0 otherwise.

Test Plan:
1. Single read at time 0, addr 33'h0_0004_0C40 -> ACT at sim_time 2 (bg=1, bank=0, addr=1); RD at 50 (addr=3); PRE at 106; q_empty=1 at 154.
2. Single write at time 0, same addr -> ACT at 2, WR at 50, PRE at 98, q_empty=1 at 146.
3. Queue empty, next request time 1000, sim_time=10 -> sim_time=1000 next cycle; req_accept=1 at 1000; ACT at 1002.
4. 17 reads all at time 0 -> 16 accepted at sim_time 0..15, q_full=1, req_accept=0 until q_full drops at 154, 17th accepted at 154. Back-to-back ACTs at 2, 154, 306.
5. Opcode 3 at time 5 -> req_accept=1 at 5, q_count stays 0, no command issued.
6. rst=1 at sim_time 20 (in WAIT_RCD) -> next cycle cmd_valid=0, q_count=0, sim_time=0; no RD/PRE issued afterwards.
